mem_port_arbiter: RTL and testbench

- Shares the single 256-bit data-memory port between two cache miss engines: port 0 is the instruction cache, port 1 is the data cache.
- Sits between the cache controllers and the data memory model.
- Grants one requester at a time with round-robin priority and latches its line request.
- Drives the memory enable/write/address/data handshake, then returns the line and a one-cycle ack to the granted requester.
- Flags a memory that stays silent too long.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the
// instruction-cache (port 0) and data-cache (port 1) miss engines.
module mem_port_arbiter #(
   parameter int unsigned LINE_W  = 256,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_enable_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [LINE_W-1:0] p0_data_i,
   output logic [LINE_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_enable_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [LINE_W-1:0] p1_data_i,
   output logic [LINE_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   output logic              grant_o,
   output logic              timeout_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   localparam int unsigned OFS_W = 5;
   localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFS_W) - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t             state_q, state_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               men_q, men_d;
   logic               mwr_q, mwr_d;
   logic [ADDR_W-1:0]  maddr_q, maddr_d;
   logic [LINE_W-1:0]  mdat_q, mdat_d;
   logic               grant_q, grant_d;
   logic               tmo_q, tmo_d;
   logic [LINE_W-1:0]  p0d_q, p0d_d, p1d_q, p1d_d;
   logic               p0ack_q, p0ack_d, p1ack_q, p1ack_d;
   logic               sel;

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      men_d   = men_q;
      mwr_d   = mwr_q;
      maddr_d = maddr_q;
      mdat_d  = mdat_q;
      grant_d = grant_q;
      tmo_d   = tmo_q;
      p0d_d   = p0d_q;
      p1d_d   = p1d_q;
      p0ack_d = 1'b0;
      p1ack_d = 1'b0;
      sel     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (p0_enable_i || p1_enable_i) begin
               // On a tie the port that was not served last wins
               sel     = (p0_enable_i && p1_enable_i) ? ~last_q : p1_enable_i;
               mwr_d   = sel ? p1_write_i : p0_write_i;
               maddr_d = (sel ? p1_addr_i : p0_addr_i) & LINE_MASK;
               mdat_d  = sel ? p1_data_i : p0_data_i;
               men_d   = 1'b1;
               grant_d = sel;
               last_d  = sel;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ack_i) begin
               if (!mwr_q) begin
                  if (grant_q) p1d_d = mem_data_i;
                  else         p0d_d = mem_data_i;
               end
               p0ack_d = ~grant_q;
               p1ack_d = grant_q;
               men_d   = 1'b0;
               mwr_d   = 1'b0;
               state_d = S_DONE;
            end else begin
               if (cnt_q == CNT_W'(TIMEOUT - 1)) tmo_d = 1'b1;
               if (cnt_q != CNT_W'(TIMEOUT))     cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         men_q   <= 1'b0;
         mwr_q   <= 1'b0;
         maddr_q <= '0;
         mdat_q  <= '0;
         grant_q <= 1'b0;
         tmo_q   <= 1'b0;
         p0d_q   <= '0;
         p1d_q   <= '0;
         p0ack_q <= 1'b0;
         p1ack_q <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         men_q   <= men_d;
         mwr_q   <= mwr_d;
         maddr_q <= maddr_d;
         mdat_q  <= mdat_d;
         grant_q <= grant_d;
         tmo_q   <= tmo_d;
         p0d_q   <= p0d_d;
         p1d_q   <= p1d_d;
         p0ack_q <= p0ack_d;
         p1ack_q <= p1ack_d;
      end
   end

   assign mem_enable_o = men_q;
   assign mem_write_o  = mwr_q;
   assign mem_addr_o   = maddr_q;
   assign mem_data_o   = mdat_q;
   assign grant_o      = grant_q;
   assign timeout_o    = tmo_q;
   assign p0_data_o    = p0d_q;
   assign p1_data_o    = p1d_q;
   assign p0_ack_o     = p0ack_q;
   assign p1_ack_o     = p1ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// of arbitration, latched payloads, returned lines and the sticky timeout.
module tb_mem_port_arbiter;

   localparam int unsigned LW      = 256;
   localparam int unsigned AW      = 32;
   localparam int unsigned TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          en   [2];
   logic          wr   [2];
   logic [AW-1:0] addr [2];
   logic [LW-1:0] wdat [2];
   logic [LW-1:0] pd   [2];
   logic          ack  [2];
   logic [LW-1:0] mem_rdata;
   logic          mem_ack;
   logic          mem_enable_o, mem_write_o, grant_o, timeout_o;
   logic [AW-1:0] mem_addr_o;
   logic [LW-1:0] mem_data_o;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int            last_m;
   logic [LW-1:0] pdat_m [2];
   bit            tmo_m;

   mem_port_arbiter #(.LINE_W(LW), .ADDR_W(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk_i(clk), .rst_i(rst),
      .p0_enable_i(en[0]), .p0_write_i(wr[0]), .p0_addr_i(addr[0]), .p0_data_i(wdat[0]),
      .p0_data_o(pd[0]), .p0_ack_o(ack[0]),
      .p1_enable_i(en[1]), .p1_write_i(wr[1]), .p1_addr_i(addr[1]), .p1_data_i(wdat[1]),
      .p1_data_o(pd[1]), .p1_ack_o(ack[1]),
      .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [LW-1:0] rand_line();
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [LW-1:0] fill(input logic [7:0] b);
      logic [LW-1:0] v;
      for (int i = 0; i < LW / 8; i++) v[i*8 +: 8] = b;
      return v;
   endfunction

   // One full transaction: grant, dly silent memory cycles, ack with md.
   // Enables must already be set before the sampling edge.
   task automatic serve(input int dly, input logic [LW-1:0] md, input bit drop);
      int            w;
      logic          ew;
      logic [AW-1:0] ea;
      logic [LW-1:0] ed;
      w  = (en[0] && en[1]) ? 1 - last_m : (en[1] ? 1 : 0);
      last_m = w;
      ew = wr[w];
      ea = {addr[w][AW-1:5], 5'b0};
      ed = wdat[w];
      @(negedge clk);
      check("grant_en",   LW'(mem_enable_o), LW'(1));
      check("grant_port", LW'(grant_o), LW'(w));
      check("grant_addr", LW'(mem_addr_o), LW'(ea));
      check("grant_wr",   LW'(mem_write_o), LW'(ew));
      check("grant_data", mem_data_o, ed);
      for (int k = 1; k <= dly; k++) begin
         if ($urandom_range(0, 1) == 1) begin
            addr[w] = $urandom;
            wdat[w] = rand_line();
         end
         mem_rdata = rand_line();
         @(negedge clk);
         check("busy_en",   LW'(mem_enable_o), LW'(1));
         check("busy_addr", LW'(mem_addr_o), LW'(ea));
         check("busy_wr",   LW'(mem_write_o), LW'(ew));
         check("busy_data", mem_data_o, ed);
         check("busy_ack",  LW'({ack[1], ack[0]}), LW'(0));
         check("busy_tmo",  LW'(timeout_o), LW'(tmo_m || k >= int'(TIMEOUT)));
      end
      if (dly >= int'(TIMEOUT)) tmo_m = 1'b1;
      mem_ack   = 1'b1;
      mem_rdata = md;
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = rand_line();
      if (!ew) pdat_m[w] = md;
      check("ack_win",   LW'(ack[w]), LW'(1));
      check("ack_lose",  LW'(ack[1-w]), LW'(0));
      check("ack_dwin",  pd[w], pdat_m[w]);
      check("ack_dlose", pd[1-w], pdat_m[1-w]);
      check("ack_men",   LW'({mem_enable_o, mem_write_o}), LW'(0));
      check("ack_tmo",   LW'(timeout_o), LW'(tmo_m));
      if (drop) en[w] = 1'b0;
      @(negedge clk);
      check("gap_ack", LW'({ack[1], ack[0]}), LW'(0));
      check("gap_men", LW'(mem_enable_o), LW'(0));
   endtask

   task automatic new_req(input int p);
      en[p]   = 1'b1;
      wr[p]   = 1'($urandom_range(0, 1));
      addr[p] = $urandom;
      wdat[p] = rand_line();
   endtask

   task automatic model_reset();
      last_m    = 1;
      pdat_m[0] = '0;
      pdat_m[1] = '0;
      tmo_m     = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      mem_ack = 1'b0;
      mem_rdata = '0;
      for (int p = 0; p < 2; p++) begin
         en[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdat[p] = '0;
      end
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_men",  LW'({mem_enable_o, mem_write_o}), LW'(0));
      check("rst_addr", LW'(mem_addr_o), LW'(0));
      check("rst_data", mem_data_o, '0);
      check("rst_pd0",  pd[0], '0);
      check("rst_pd1",  pd[1], '0);
      check("rst_misc", LW'({ack[1], ack[0], grant_o, timeout_o}), LW'(0));
      rst = 1'b0;
      @(negedge clk);

      // Port 0 line read with a slow memory
      en[0] = 1'b1; wr[0] = 1'b0; addr[0] = 32'h0000_1234; wdat[0] = rand_line();
      serve(10, fill(8'hAA), 1'b1);
      check("p0_read_line", pd[0], fill(8'hAA));

      // Port 1 line write
      en[1] = 1'b1; wr[1] = 1'b1; addr[1] = 32'h0000_0400; wdat[1] = fill(8'h5A);
      serve(3, rand_line(), 1'b1);

      // Both ports requesting continuously: grants alternate
      new_req(0);
      new_req(1);
      for (int i = 0; i < 4; i++) begin
         check("rr_order", LW'(1 - last_m), LW'(i % 2));
         serve(2, rand_line(), 1'b0);
      end
      en[0] = 1'b0;
      en[1] = 1'b0;
      @(negedge clk);

      // Random mix of single, pending and simultaneous requests
      for (int it = 0; it < 40; it++) begin
         if (!en[0] && !en[1]) begin
            case ($urandom_range(0, 2))
               0: new_req(0);
               1: new_req(1);
               default: begin new_req(0); new_req(1); end
            endcase
         end else if ($urandom_range(0, 2) == 0) begin
            if (!en[0]) new_req(0);
            else        new_req(1);
         end
         serve(int'($urandom_range(0, 6)), rand_line(), 1'b1);
      end
      en[0] = 1'b0;
      en[1] = 1'b0;
      @(negedge clk);

      // Silent memory: timeout sets, late ack still completes, flag stays
      new_req(0);
      serve(70, rand_line(), 1'b1);
      new_req(1);
      serve(1, rand_line(), 1'b1);
      new_req(0);
      serve(0, rand_line(), 1'b1);

      // Reset while busy abandons the transaction
      new_req(0);
      wr[0] = 1'b0;
      last_m = 0;
      @(negedge clk);
      check("rb_grant", LW'(mem_enable_o), LW'(1));
      repeat (3) @(negedge clk);
      rst = 1'b1;
      mem_ack = 1'b1;
      mem_rdata = rand_line();
      @(negedge clk);
      rst = 1'b0;
      mem_ack = 1'b0;
      en[0] = 1'b0;
      model_reset();
      check("rb_men",  LW'(mem_enable_o), LW'(0));
      check("rb_misc", LW'({ack[1], ack[0], grant_o, timeout_o}), LW'(0));
      check("rb_pd0",  pd[0], '0);
      @(negedge clk);
      check("rb_noack", LW'({ack[1], ack[0]}), LW'(0));
      check("rb_idle",  LW'(mem_enable_o), LW'(0));
      new_req(0);
      new_req(1);
      serve(1, rand_line(), 1'b1);
      check("rb_tie_p0", LW'(last_m), LW'(0));
      serve(1, rand_line(), 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
